// File: rtl/instr_decode_pkg.sv
// Shared opcode map, ALU encoding, field layout and decode table for the
// decode stage.
package instr_decode_pkg;

  localparam int INSTR_W      = 32;
  localparam int OP_W         = 6;
  localparam int REG_FIELD_W  = 5;
  localparam int IMM_FIELD_W  = 16;
  localparam int ADDR_FIELD_W = 8;

  localparam int OP_LSB      = 26;
  localparam int RD2_LSB     = 21;
  localparam int RD1_LSB     = 16;
  localparam int RS2_LSB     = 5;
  localparam int RS1_LSB     = 0;
  localparam int IMM_LSB     = 0;
  localparam int LD_ADDR_LSB = 0;
  localparam int ST_ADDR_LSB = 18;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_LDI  = 6'h00;
  localparam opcode_t OP_MOV  = 6'h01;
  localparam opcode_t OP_LD   = 6'h02;
  localparam opcode_t OP_ST   = 6'h03;
  localparam opcode_t OP_ADD  = 6'h04;
  localparam opcode_t OP_SUB  = 6'h05;
  localparam opcode_t OP_NEG  = 6'h06;
  localparam opcode_t OP_MUL  = 6'h07;
  localparam opcode_t OP_AND  = 6'h08;
  localparam opcode_t OP_OR   = 6'h09;
  localparam opcode_t OP_NAND = 6'h0A;
  localparam opcode_t OP_NOR  = 6'h0B;
  localparam opcode_t OP_XOR  = 6'h0C;
  localparam opcode_t OP_XNOR = 6'h0D;
  localparam opcode_t OP_NOT  = 6'h0E;
  localparam opcode_t OP_SHL  = 6'h0F;
  localparam opcode_t OP_SHR  = 6'h10;
  localparam opcode_t OP_NOP  = 6'h11;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_NEG  = 5'd3,
    ALU_MUL  = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_NAND = 5'd7,
    ALU_NOR  = 5'd8,
    ALU_XOR  = 5'd9,
    ALU_XNOR = 5'd10,
    ALU_NOT  = 5'd11,
    ALU_SHL  = 5'd12,
    ALU_SHR  = 5'd13,
    ALU_PASS = 5'd14
  } alu_op_t;

  // Fields are kept at instruction width; the top narrows them to its parameters.
  typedef struct packed {
    alu_op_t                 aluop;
    logic [REG_FIELD_W-1:0]  rd1;
    logic [REG_FIELD_W-1:0]  rd2;
    logic [REG_FIELD_W-1:0]  rs1;
    logic [REG_FIELD_W-1:0]  rs2;
    logic                    we_rd1;
    logic                    we_rd2;
    logic                    re_rs1;
    logic                    re_rs2;
    logic [IMM_FIELD_W-1:0]  imm;
    logic [ADDR_FIELD_W-1:0] maddr;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    illegal;
  } decoded_t;

  function automatic alu_op_t alu_of(input opcode_t op);
    alu_op_t a;
    case (op)
      OP_LDI, OP_MOV, OP_LD, OP_ST: a = ALU_PASS;
      OP_ADD:  a = ALU_ADD;
      OP_SUB:  a = ALU_SUB;
      OP_NEG:  a = ALU_NEG;
      OP_MUL:  a = ALU_MUL;
      OP_AND:  a = ALU_AND;
      OP_OR:   a = ALU_OR;
      OP_NAND: a = ALU_NAND;
      OP_NOR:  a = ALU_NOR;
      OP_XOR:  a = ALU_XOR;
      OP_XNOR: a = ALU_XNOR;
      OP_NOT:  a = ALU_NOT;
      OP_SHL:  a = ALU_SHL;
      OP_SHR:  a = ALU_SHR;
      default: a = ALU_NOP;
    endcase
    return a;
  endfunction

  function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
    decoded_t d;
    opcode_t  op;
    logic [REG_FIELD_W-1:0] f_rd1, f_rd2, f_rs1, f_rs2;
    op    = instr[OP_LSB +: OP_W];
    f_rd1 = instr[RD1_LSB +: REG_FIELD_W];
    f_rd2 = instr[RD2_LSB +: REG_FIELD_W];
    f_rs1 = instr[RS1_LSB +: REG_FIELD_W];
    f_rs2 = instr[RS2_LSB +: REG_FIELD_W];
    d       = '0;
    d.aluop = alu_of(op);
    case (op)
      OP_LDI: begin
        d.rd2    = f_rd2;
        d.we_rd2 = 1'b1;
        d.imm    = instr[IMM_LSB +: IMM_FIELD_W];
      end
      OP_MOV: begin
        d.rd2    = f_rd2;
        d.we_rd2 = 1'b1;
        d.rs1    = f_rs1;
        d.re_rs1 = 1'b1;
      end
      OP_LD: begin
        d.rd2    = f_rd2;
        d.we_rd2 = 1'b1;
        d.maddr  = instr[LD_ADDR_LSB +: ADDR_FIELD_W];
        d.mem_rd = 1'b1;
      end
      OP_ST: begin
        // The store address overlays the rd2/rd1 fields, so no destination.
        d.rs1    = f_rs1;
        d.re_rs1 = 1'b1;
        d.maddr  = instr[ST_ADDR_LSB +: ADDR_FIELD_W];
        d.mem_wr = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NAND, OP_NOR,
      OP_XOR, OP_XNOR, OP_SHL, OP_SHR: begin
        d.rd1    = f_rd1;
        d.we_rd1 = 1'b1;
        d.rs1    = f_rs1;
        d.rs2    = f_rs2;
        d.re_rs1 = 1'b1;
        d.re_rs2 = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        d.rd1    = f_rd1;
        d.we_rd1 = 1'b1;
        d.rs1    = f_rs1;
        d.re_rs1 = 1'b1;
      end
      OP_MUL: begin
        d.rd1    = f_rd1;
        d.rd2    = f_rd2;
        d.we_rd1 = 1'b1;
        d.we_rd2 = 1'b1;
        d.rs1    = f_rs1;
        d.rs2    = f_rs2;
        d.re_rs1 = 1'b1;
        d.re_rs2 = 1'b1;
      end
      OP_NOP: ;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_scoreboard.sv
// Register busy bitmap: destinations of accepted instructions are marked busy
// until writeback; flags RAW/WAW hazards for the instruction at the input.
module instr_decode_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             we_rd1,
  input  logic             we_rd2,
  input  logic             re_rs1,
  input  logic             re_rs2,
  input  logic [REG_W-1:0] rd1,
  input  logic [REG_W-1:0] rd2,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  output logic             hazard
);
  import instr_decode_pkg::*;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [NUM_REGS-1:0] busy_eff;

  always_comb begin
    clr = '0;
    set = '0;
    if (wb_valid) clr[wb_reg] = 1'b1;
    // A MUL with rd1 == rd2 simply sets the same bit twice.
    if (accept && we_rd1) set[rd1] = 1'b1;
    if (accept && we_rd2) set[rd2] = 1'b1;
  end

  // Same-cycle writeback already counts as released for the hazard check.
  assign busy_eff = busy & ~clr;

  assign hazard = (re_rs1 && busy_eff[rs1]) ||
                  (re_rs2 && busy_eff[rs2]) ||
                  (we_rd1 && busy_eff[rd1]) ||
                  (we_rd2 && busy_eff[rd2]);

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_eff | set;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered, handshaked instruction decode stage with a one-entry output
// register. Define INSTR_DECODE_SCOREBOARD_EN to enable the hazard scoreboard.
module instr_decode_stage #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int MADDR_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4:0]                  out_aluop,
  output logic [$clog2(NUM_REGS)-1:0] out_rd1,
  output logic [$clog2(NUM_REGS)-1:0] out_rd2,
  output logic [$clog2(NUM_REGS)-1:0] out_rs1,
  output logic [$clog2(NUM_REGS)-1:0] out_rs2,
  output logic                        out_we_rd1,
  output logic                        out_we_rd2,
  output logic                        out_re_rs1,
  output logic                        out_re_rs2,
  output logic [DATA_W-1:0]           out_imm,
  output logic [MADDR_W-1:0]          out_maddr,
  output logic                        out_mem_rd,
  output logic                        out_mem_wr,
  output logic                        out_illegal,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_reg
);
  import instr_decode_pkg::*;

  localparam int REG_W = $clog2(NUM_REGS);

  decoded_t dec;
  decoded_t held;
  logic     hazard;
  logic     accept;

  assign dec = decode_instr(in_instr);

`ifdef INSTR_DECODE_SCOREBOARD_EN
  instr_decode_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .we_rd1   (dec.we_rd1),
    .we_rd2   (dec.we_rd2),
    .re_rs1   (dec.re_rs1),
    .re_rs2   (dec.re_rs2),
    .rd1      (dec.rd1[REG_W-1:0]),
    .rd2      (dec.rd2[REG_W-1:0]),
    .rs1      (dec.rs1[REG_W-1:0]),
    .rs2      (dec.rs2[REG_W-1:0]),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .hazard   (hazard)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_reg};
  assign hazard    = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_aluop   = held.aluop;
  assign out_rd1     = held.rd1[REG_W-1:0];
  assign out_rd2     = held.rd2[REG_W-1:0];
  assign out_rs1     = held.rs1[REG_W-1:0];
  assign out_rs2     = held.rs2[REG_W-1:0];
  assign out_we_rd1  = held.we_rd1;
  assign out_we_rd2  = held.we_rd2;
  assign out_re_rs1  = held.re_rs1;
  assign out_re_rs2  = held.re_rs2;
  assign out_imm     = DATA_W'(held.imm);
  assign out_maddr   = MADDR_W'(held.maddr);
  assign out_mem_rd  = held.mem_rd;
  assign out_mem_wr  = held.mem_wr;
  assign out_illegal = held.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, handshaked instruction-decode stage for the 16-bit Harvard core. It accepts one 32-bit instruction per cycle from fetch and decodes the 6-bit opcode into register addresses, ALU operation, immediate, memory-address and write-enable controls. It presents the result to execute through a one-entry pipeline register. An optional register scoreboard stalls fetch on RAW/WAW hazards until writeback clears the destination.

## Interface
Parameters:
- DATA_W, 16: datapath width; immediate is zero-extended or truncated to this width.
- NUM_REGS, 32: register count; register fields are log2(NUM_REGS) bits, taken from the LSBs of each 5-bit field.
- MADDR_W, 8: data-memory direct-address width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute consumes.
- out_aluop  out  5  alu_op_t encoding.
- out_rd1, out_rd2, out_rs1, out_rs2  out  log2(NUM_REGS) each  register addresses.
- out_we_rd1, out_we_rd2  out  1 each  destination write enables.
- out_re_rs1, out_re_rs2  out  1 each  source read enables.
- out_imm  out  DATA_W  immediate.
- out_maddr  out  MADDR_W  memory address.
- out_mem_rd, out_mem_wr  out  1 each  load/store.
- out_illegal  out  1  undefined opcode.
- wb_valid  in  1  writeback completes one register.
- wb_reg  in  log2(NUM_REGS)  register written back.

## Operation
- Fields: op=[31:26], rd2=[25:21], rd1=[20:16], rs2=[9:5], rs1=[4:0].
- 000000 LDI: rd2 ← instr[15:0]. Sets we_rd2.
- 000001 MOV: rd2 ← rs1. Uses instr[4:0].
- 000010 LD: rd2 ← mem[instr[7:0]]. Sets mem_rd.
- 000011 ST: mem[instr[25:18]] ← rs1. Uses instr[4:0]. Sets mem_wr.
- 000100 ADD, 000101 SUB, 001000 AND, 001001 OR, 001010 NAND, 001011 NOR, 001100 XOR, 001101 XNOR, 001111 SHL, 010000 SHR: rd1 ← rs2 op rs1. Sets we_rd1, re_rs1 and re_rs2. For shifts, rs1 supplies the shift amount.
- 000110 NEG, 001110 NOT: rd1 ← op rs1. Sets re_rs1.
- 000111 MUL: {rd2,rd1} ← rs2×rs1. Upper half goes to rd2. Sets we_rd1 and we_rd2.
- 010001 NOP: all enables 0.
- Opcodes ≥ 010010 are illegal: out_illegal=1, aluop=NOP, all enables 0. Illegal instructions are still passed downstream.
- Unused output fields are driven to 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is valid at out_* after edge N.
- Transfer occurs on valid&&ready. in_ready = (!out_valid || out_ready) && !hazard.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous drain and accept gives back-to-back throughput of 1 instruction per cycle.
- Reset: out_valid=0, all out_* = 0, and the scoreboard is cleared. A held instruction is discarded. Reset asserted mid-stall drops the stall.
- Scoreboard: busy[NUM_REGS].
  - hazard = enabled source busy, or enabled destination busy (WAW).
  - Hazard evaluation uses busy & ~(wb_valid ? onehot(wb_reg) : 0), so a same-cycle writeback releases the stall that cycle.
  - busy_next = (busy & ~clr) | set. set comes from accepted destinations. If one register is both cleared and set in a cycle, it ends busy.
  - MUL sets two bits. If rd1==rd2 for MUL, one bit is set.
  - wb to a non-busy register is ignored.
- An accepted illegal or NOP instruction sets no bits.

## Configuration
- INSTR_DECODE_SCOREBOARD_EN defined: the scoreboard and hazard stall operate as above.
- INSTR_DECODE_SCOREBOARD_EN undefined: there is no busy register and hazard=0. wb_valid and wb_reg are present but ignored. in_ready = !out_valid || out_ready.

## Structure
- Package instr_decode_pkg holds:
  - opcode_t localparams (6-bit).
  - alu_op_t enum (NOP, ADD, SUB, NEG, MUL, AND, OR, NAND, NOR, XOR, XNOR, NOT, SHL, SHR, PASS).
  - Field-position constants.
  - decoded_t struct.
- One sub-module, instr_decode_scoreboard: busy bitmap, set/clear and hazard compare. It is instantiated only under the macro.
- The decode table is combinational in the top. It feeds the pipeline register.

## Test plan
- Reset, then ADD rd1=3 rs2=1 rs1=2 (0x10030022), out_ready=1 → next cycle out_aluop=ADD, out_rd1=3, out_rs2=1, out_rs1=2, we_rd1=1, we_rd2=0.
- LDI rd2=7 imm=0xBEEF → out_imm=0xBEEF, we_rd2=1. ST addr=0x5A rs1=4 → out_maddr=0x5A, mem_wr=1, out_rs1=4.
- Opcode 0x3F → out_illegal=1, all enables 0, scoreboard unchanged. Following NOP → out_illegal=0.
- Scoreboard on: MUL rd2=5 rd1=6, then ADD rs1=6 → in_ready=0 for every cycle until wb_valid wb_reg=6 with wb 5 outstanding. ADD is accepted in the wb cycle. Reissuing MUL rd2=5 stalls until wb 5.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → out_* stable, in_ready=0. out_ready=1 → two instructions transfer on consecutive cycles.
- Scoreboard on, rst asserted while a stall is pending → next cycle busy=0, out_valid=0, in_ready=1.
